// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM single-port memory arbiter.
// State encodings stay plain 2-bit constants so legacy define-based code can match them.
package mem_port_arbiter_pkg;

  localparam int ISIZE          = 16;
  localparam int ARB_STARVE_MAX = 3;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_BUSY_I = 2'b01;
  localparam logic [1:0] ARB_BUSY_D = 2'b10;

  // Saturating increment used by the fetch-starvation counter.
  function automatic logic [2:0] satInc(input logic [2:0] value, input logic [2:0] limit);
    return (value >= limit) ? limit : value + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage.
// Data accesses win by default; fetch is forced after STARVE_MAX consecutive data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ASIZE      = 16,
  parameter int DSIZE      = ISIZE,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [ASIZE-1:0] if_addr,
  input  logic             flush,
  output logic [DSIZE-1:0] if_rdata,
  output logic             if_valid,
  input  logic             dm_en,
  input  logic             dm_wr_n,
  input  logic [ASIZE-1:0] dm_addr,
  input  logic [DSIZE-1:0] dm_wdata,
  output logic [DSIZE-1:0] dm_rdata,
  output logic             dm_done,
  output logic             stall_if,
  output logic             stall_mem,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

  logic [1:0]       stateReg, stateNext;
  logic [2:0]       starveCnt;
  logic             fetchCancel;
  logic             memReqReg, memWeReg;
  logic [ASIZE-1:0] memAddrReg;
  logic [DSIZE-1:0] memWdataReg, ifRdataReg, dmRdataReg;
  logic             ifValidReg, dmDoneReg;

  logic isIdle, busyI, busyD, arbPoint;
  logic dataPend, fetchPend, starved, grantI, grantD;
  logic fetchAck, dataAck, fetchDeliver;

  always_comb begin
    isIdle    = (stateReg == ARB_IDLE);
    busyI     = (stateReg == ARB_BUSY_I);
    busyD     = (stateReg == ARB_BUSY_D);
    arbPoint  = isIdle | ((busyI | busyD) & mem_ack);
    fetchAck  = busyI & mem_ack;
    dataAck   = busyD & mem_ack;
    dataPend  = dm_en & ~dmDoneReg;
    // if_req is held through its own ack, so the fetch being acked is not a new request.
    fetchPend = if_req & ~ifValidReg & ~fetchAck & ~flush;
    starved   = (starveCnt == STARVE_LIMIT);
    grantI    = arbPoint & fetchPend & (~dataPend | starved);
    grantD    = arbPoint & dataPend & ~grantI;
    // A flush landing on the ack cycle cancels delivery just like a stored cancel.
    fetchDeliver = fetchAck & ~fetchCancel & ~flush;

    stateNext = stateReg;
    if (arbPoint) begin
      if (grantI)      stateNext = ARB_BUSY_I;
      else if (grantD) stateNext = ARB_BUSY_D;
      else             stateNext = ARB_IDLE;
    end else if (!busyI && !busyD) begin
      stateNext = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= ARB_IDLE;
      starveCnt   <= 3'd0;
      fetchCancel <= 1'b0;
      memReqReg   <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      ifRdataReg  <= '0;
      dmRdataReg  <= '0;
      ifValidReg  <= 1'b0;
      dmDoneReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      memReqReg <= (stateNext != ARB_IDLE);

      if (grantD) begin
        memAddrReg  <= dm_addr;
        memWeReg    <= ~dm_wr_n;
        memWdataReg <= dm_wdata;
        starveCnt   <= if_req ? satInc(starveCnt, STARVE_LIMIT) : 3'd0;
      end else if (grantI) begin
        memAddrReg <= if_addr;
        memWeReg   <= 1'b0;
        starveCnt  <= 3'd0;
      end

      dmDoneReg <= dataAck;
      if (dataAck && !memWeReg) dmRdataReg <= mem_rdata;

      ifValidReg <= fetchDeliver;
      if (fetchDeliver) ifRdataReg <= mem_rdata;

      if (fetchAck)           fetchCancel <= 1'b0;
      else if (busyI & flush) fetchCancel <= 1'b1;
    end
  end

  assign mem_req   = memReqReg;
  assign mem_we    = memWeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign if_rdata  = ifRdataReg;
  assign if_valid  = ifValidReg;
  assign dm_rdata  = dmRdataReg;
  assign dm_done   = dmDoneReg;
  assign stall_if  = if_req & ~ifValidReg;
  assign stall_mem = dm_en & ~dmDoneReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation, flush cancellation and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, flush, dm_en, dm_wr_n, mem_ack;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_done, stall_if, stall_mem, mem_req, mem_we;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ASIZE(16), .DSIZE(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_en(dm_en), .dm_wr_n(dm_wr_n), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        flush;
    logic        dmEn;
    logic        dmWrN;
    logic [15:0] dmAddr;
    logic [15:0] dmWdata;
    logic [15:0] memRdata;
    logic        memAck;
    logic        eMemReq;
    logic        eMemWe;
    logic [15:0] eMemAddr;
    logic [15:0] eMemWdata;
    logic        eIfValid;
    logic [15:0] eIfRdata;
    logic        eDmDone;
    logic [15:0] eDmRdata;
    logic        eStallIf;
    logic        eStallMem;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idleInputs();
    if_req = 0; if_addr = 16'h0; flush = 0; dm_en = 0; dm_wr_n = 1;
    dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0; mem_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected outputs are what is visible during the row's cycle (state left by the previous edge).
    //           ifReq ifAddr  fl  dmEn wrN dmAddr   dmWdata  memRd    ack | req we addr     wdata    ifV ifRdata  done dmRdata stI stM
    vecs[0]  = '{1, 16'h0010, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0};
    vecs[1]  = '{1, 16'h0010, 0, 0, 1, 16'h0000, 16'h0000, 16'hA123, 1,  1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0};
    vecs[2]  = '{1, 16'h0010, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0, 16'h0010, 16'h0000, 1, 16'hA123, 0, 16'h0000, 0, 0};
    vecs[3]  = '{0, 16'h0010, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0, 16'h0010, 16'h0000, 0, 16'hA123, 0, 16'h0000, 0, 0};
    vecs[4]  = '{1, 16'h0020, 0, 1, 1, 16'h0040, 16'h0000, 16'h0000, 0,  0, 0, 16'h0010, 16'h0000, 0, 16'hA123, 0, 16'h0000, 1, 1};
    vecs[5]  = '{1, 16'h0020, 0, 0, 1, 16'h0040, 16'h0000, 16'h5555, 1,  1, 0, 16'h0040, 16'h0000, 0, 16'hA123, 0, 16'h0000, 1, 0};
    vecs[6]  = '{1, 16'h0020, 0, 0, 1, 16'h0040, 16'h0000, 16'h1234, 1,  1, 0, 16'h0020, 16'h0000, 0, 16'hA123, 1, 16'h5555, 1, 0};
    vecs[7]  = '{0, 16'h0020, 0, 0, 1, 16'h0040, 16'h0000, 16'h0000, 0,  0, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0, 16'h5555, 0, 0};
    vecs[8]  = '{0, 16'h0020, 0, 1, 0, 16'h0002, 16'hBEEF, 16'h0000, 0,  0, 0, 16'h0020, 16'h0000, 0, 16'h1234, 0, 16'h5555, 0, 1};
    vecs[9]  = '{0, 16'h0020, 0, 1, 0, 16'h0002, 16'hBEEF, 16'h0000, 0,  1, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 0, 16'h5555, 0, 1};
    vecs[10] = '{0, 16'h0020, 0, 1, 0, 16'h0002, 16'hBEEF, 16'h0000, 0,  1, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 0, 16'h5555, 0, 1};
    vecs[11] = '{0, 16'h0020, 0, 1, 0, 16'h0002, 16'hBEEF, 16'h0000, 0,  1, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 0, 16'h5555, 0, 1};
    vecs[12] = '{0, 16'h0020, 0, 0, 0, 16'h0002, 16'hBEEF, 16'hDEAD, 1,  1, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 0, 16'h5555, 0, 0};
    vecs[13] = '{0, 16'h0020, 0, 1, 1, 16'h0006, 16'h0000, 16'h0000, 0,  0, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 1, 16'h5555, 0, 0};
    vecs[14] = '{0, 16'h0020, 0, 0, 1, 16'h0006, 16'h0000, 16'h0000, 0,  0, 1, 16'h0002, 16'hBEEF, 0, 16'h1234, 0, 16'h5555, 0, 0};

    // Reset state
    idleInputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset if_valid", if_valid, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset dm_done", dm_done, 0);
    chk("reset dm_rdata", dm_rdata, 0);
    chk("reset state", dut.stateReg, 0);
    chk("reset starve_cnt", dut.starveCnt, 0);
    $display("[TB] reset checked");
    rst_n = 1;

    // Per-cycle vector table: fetch only, data-vs-fetch contention, delayed-ack store
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      if_req = vecs[i].ifReq;   if_addr = vecs[i].ifAddr; flush = vecs[i].flush;
      dm_en = vecs[i].dmEn;     dm_wr_n = vecs[i].dmWrN;  dm_addr = vecs[i].dmAddr;
      dm_wdata = vecs[i].dmWdata; mem_rdata = vecs[i].memRdata; mem_ack = vecs[i].memAck;
      #1;
      chk($sformatf("row%0d mem_req", i), mem_req, vecs[i].eMemReq);
      chk($sformatf("row%0d mem_we", i), mem_we, vecs[i].eMemWe);
      chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].eMemAddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].eMemWdata);
      chk($sformatf("row%0d if_valid", i), if_valid, vecs[i].eIfValid);
      chk($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].eIfRdata);
      chk($sformatf("row%0d dm_done", i), dm_done, vecs[i].eDmDone);
      chk($sformatf("row%0d dm_rdata", i), dm_rdata, vecs[i].eDmRdata);
      chk($sformatf("row%0d stall_if", i), stall_if, vecs[i].eStallIf);
      chk($sformatf("row%0d stall_mem", i), stall_mem, vecs[i].eStallMem);
      $display("[TB] row %0d: req=%b we=%b addr=%h ifv=%b done=%b", i, mem_req, mem_we, mem_addr, if_valid, dm_done);
    end

    // Flush in the second BUSY_I cycle, ack in the third; then fetch at the target
    @(negedge clk); idleInputs(); if_req = 1; if_addr = 16'h0030;
    @(negedge clk); #1;
    chk("flush grant mem_req", mem_req, 1);
    chk("flush grant mem_addr", mem_addr, 16'h0030);
    @(negedge clk); flush = 1; if_req = 0;
    @(negedge clk); flush = 0; if_req = 1; if_addr = 16'h0080; mem_ack = 1; mem_rdata = 16'h7777;
    #1;
    chk("flush cancel set", dut.fetchCancel, 1);
    chk("flush not aborted", mem_req, 1);
    chk("flush addr held", mem_addr, 16'h0030);
    @(negedge clk); mem_ack = 0; #1;
    chk("flush if_valid suppressed", if_valid, 0);
    chk("flush if_rdata kept", if_rdata, 16'h1234);
    chk("flush cancel cleared", dut.fetchCancel, 0);
    @(negedge clk); #1;
    chk("target grant mem_req", mem_req, 1);
    chk("target grant mem_addr", mem_addr, 16'h0080);
    mem_ack = 1; mem_rdata = 16'h8888;
    @(negedge clk); if_req = 0; mem_ack = 0; #1;
    chk("target if_valid", if_valid, 1);
    chk("target if_rdata", if_rdata, 16'h8888);
    $display("[TB] flush sequence done: if_rdata=%h", if_rdata);

    // Reset asserted while a data read is outstanding
    @(negedge clk); idleInputs(); dm_en = 1; dm_wr_n = 1; dm_addr = 16'h0004;
    @(negedge clk); #1;
    chk("rst pre mem_req", mem_req, 1);
    #2 rst_n = 0; #1;
    chk("rst async mem_req", mem_req, 0);
    chk("rst async dm_done", dm_done, 0);
    chk("rst async if_valid", if_valid, 0);
    @(negedge clk); rst_n = 1; dm_en = 0; mem_ack = 1;
    @(negedge clk); mem_ack = 0; #1;
    chk("stray ack dm_done", dm_done, 0);
    chk("stray ack if_valid", if_valid, 0);
    chk("stray ack mem_req", mem_req, 0);
    chk("stray ack state", dut.stateReg, 0);
    $display("[TB] reset sequence done");

    // Continuous contention: ack on the second cycle of every transaction
    begin
      logic [15:0] expAddr [8];
      logic [2:0]  expCnt  [8];
      expAddr = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0100};
      expCnt  = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      @(negedge clk); idleInputs();
      if_req = 1; if_addr = 16'h0100; dm_en = 1; dm_wr_n = 1; dm_addr = 16'h0200;
      for (int g = 0; g < 8; g++) begin
        if (g != 0) begin
          @(negedge clk); mem_ack = 0;
          @(negedge clk); mem_ack = 1;
        end
        @(posedge clk); #1;
        chk($sformatf("grant%0d mem_addr", g), mem_addr, expAddr[g]);
        chk($sformatf("grant%0d starve_cnt", g), dut.starveCnt, expCnt[g]);
        $display("[TB] grant %0d: %s addr=%h starve=%0d", g, (mem_addr == 16'h0100) ? "I" : "D", mem_addr, dut.starveCnt);
      end
      @(negedge clk); if_req = 0; dm_en = 0; mem_ack = 1;
      @(negedge clk); mem_ack = 0; #1;
      chk("starve end mem_req", mem_req, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
